// File: rtl/ntt_coef_loader.sv
// Pops FIFO A/B in lockstep, unpacks {tag,addr,coef} and writes both RAM ports; pop->ram_we is 2 cycles.
// Pops stall the same cycle either FIFO reports empty; in-flight pops always complete.
module ntt_coef_loader #(
  parameter int N  = 256,
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   fifo_a_dat,
  input  logic          fifo_a_empty,
  output logic          fifo_a_rdreq,
  input  logic [31:0]   fifo_b_dat,
  input  logic          fifo_b_empty,
  output logic          fifo_b_rdreq,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_din_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_din_b,
  output logic          busy,
  output logic          in_done,
  output logic          err
);

  localparam int BEATS = N / 2;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] written_q, written_d;
  logic          err_q, err_d;
  logic          vld_q;
  logic          ram_we_q;
  logic [AW-1:0] addr_a_q, addr_b_q;
  logic [DW-1:0] din_a_q, din_b_q;
  logic          pop;
  logic          beat_bad;
  logic [AW-1:0] exp_addr_a, exp_addr_b;

  // Beat k must carry addresses 2k / 2k+1 (mod 2^AW) and zero tags on both words.
  assign exp_addr_a = AW'({written_q, 1'b0});
  assign exp_addr_b = exp_addr_a | AW'(1);
  assign beat_bad   = (AW'(fifo_a_dat[23:16]) != exp_addr_a) ||
                      (AW'(fifo_b_dat[23:16]) != exp_addr_b) ||
                      (fifo_a_dat[31:24] != 8'h00) ||
                      (fifo_b_dat[31:24] != 8'h00);

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    written_d = written_q;
    err_d     = err_q;
    pop       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          issued_d  = '0;
          written_d = '0;
          err_d     = 1'b0;
        end
      end
      RUN: begin
        pop = !fifo_a_empty && !fifo_b_empty && (issued_q < BEATS_C);
        if (pop) issued_d = issued_q + CW'(1);
        if (vld_q) begin
          written_d = written_q + CW'(1);
          if (beat_bad) err_d = 1'b1;
        end
        // written_q already counts the beat on the ram_we cycle, so the last write lands before DONE.
        if (ram_we_q && (written_q == BEATS_C)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      issued_q  <= '0;
      written_q <= '0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      ram_we_q  <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      din_a_q   <= '0;
      din_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      written_q <= written_d;
      err_q     <= err_d;
      vld_q     <= pop;
      ram_we_q  <= vld_q;
      if (vld_q) begin
        addr_a_q <= AW'(fifo_a_dat[23:16]);
        addr_b_q <= AW'(fifo_b_dat[23:16]);
        din_a_q  <= DW'(fifo_a_dat[15:0]);
        din_b_q  <= DW'(fifo_b_dat[15:0]);
      end
    end
  end

  assign fifo_a_rdreq = pop;
  assign fifo_b_rdreq = pop;
  assign ram_we       = ram_we_q;
  assign ram_addr_a   = addr_a_q;
  assign ram_addr_b   = addr_b_q;
  assign ram_din_a    = din_a_q;
  assign ram_din_b    = din_b_q;
  assign busy         = (state_q == RUN);
  assign in_done      = (state_q == DONE);
  assign err          = err_q;

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Bench for ntt_coef_loader: behavioural FIFO pair, write monitor and expected-beat scoreboard.
module tb_ntt_coef_loader;
  localparam int N = 256, AW = 8, DW = 16;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0]   fifo_a_dat = '0, fifo_b_dat = '0;
  logic          fifo_a_empty = 1'b1, fifo_b_empty = 1'b1;
  logic          fifo_a_rdreq, fifo_b_rdreq, ram_we, busy, in_done, err;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b;

  always #5 clk = ~clk;

  ntt_coef_loader #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .fifo_a_dat(fifo_a_dat), .fifo_a_empty(fifo_a_empty), .fifo_a_rdreq(fifo_a_rdreq),
    .fifo_b_dat(fifo_b_dat), .fifo_b_empty(fifo_b_empty), .fifo_b_rdreq(fifo_b_rdreq),
    .ram_we(ram_we), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
    .busy(busy), .in_done(in_done), .err(err)
  );

  int n_cmp = 0, n_err = 0;

  // Normal-mode FIFO pair: data one cycle after rdreq, empty registered.
  logic [31:0] mem_a [0:2047];
  logic [31:0] mem_b [0:2047];
  int   wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0;
  logic stall_b = 1'b0;

  always @(posedge clk) begin
    if (fifo_a_rdreq) fifo_a_dat <= mem_a[rd_a[10:0]];
    if (fifo_b_rdreq) fifo_b_dat <= mem_b[rd_b[10:0]];
    rd_a <= rd_a + (fifo_a_rdreq ? 1 : 0);
    rd_b <= rd_b + (fifo_b_rdreq ? 1 : 0);
    fifo_a_empty <= (rd_a + (fifo_a_rdreq ? 1 : 0)) >= wr_a;
    fifo_b_empty <= ((rd_b + (fifo_b_rdreq ? 1 : 0)) >= wr_b) || stall_b;
  end

  typedef struct packed {
    int          cyc;
    logic        er;
    logic [7:0]  aa;
    logic [15:0] da;
    logic [7:0]  ab;
    logic [15:0] db;
  } obs_t;

  typedef struct packed {
    logic        bad;
    logic [7:0]  aa;
    logic [15:0] da;
    logic [7:0]  ab;
    logic [15:0] db;
  } exp_t;

  obs_t obs [$];
  exp_t exq [$];
  int   rd_obs = 0;
  int   cyc = 0, pops = 0, lone = 0, done_cyc = -1;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    pops      <= pops + (fifo_a_rdreq ? 1 : 0);
    lone      <= lone + ((fifo_a_rdreq != fifo_b_rdreq) ? 1 : 0);
    done_prev <= in_done;
    if (in_done && !done_prev) done_cyc <= cyc + 1;
    if (ram_we) obs.push_back('{cyc + 1, err, ram_addr_a, ram_din_a, ram_addr_b, ram_din_b});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic push_beat(input int k, input logic [7:0] aa, input logic [7:0] ta, input logic [7:0] tg);
    logic [7:0]  ka, ab;
    logic [15:0] da, db;
    ka = 8'(2 * k);
    ab = ka + 8'd1;
    da = 16'(aa) * 16'd3;
    db = 16'(ab) * 16'd3;
    mem_a[wr_a[10:0]] = {ta, aa, da};
    mem_b[wr_b[10:0]] = {tg, ab, db};
    wr_a++;
    wr_b++;
    exq.push_back('{(aa != ka) || (ta != 8'h00) || (tg != 8'h00), aa, da, ab, db});
  endtask

  task automatic fill(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) push_beat(k, 8'(2 * k), 8'h00, 8'h00);
  endtask

  task automatic start_load(output int t, output logic b);
    @(negedge clk); #1;
    start = 1'b1;
    t = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    b = busy;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (in_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({fifo_a_rdreq, fifo_b_rdreq, ram_we, busy, in_done, err} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 000000", {fifo_a_rdreq, fifo_b_rdreq, ram_we, busy, in_done, err});
    end
    n_cmp++;
    if ({ram_addr_a, ram_din_a, ram_addr_b, ram_din_b} !== 48'h0) begin
      n_err++; $display("FAIL reset_data: got %h required 0", {ram_addr_a, ram_din_a, ram_addr_b, ram_din_b});
    end
  endtask

  task automatic test_full_load;
    int t, bp; logic b, ok, st; obs_t o; exp_t e;
    fill(0, 127);
    repeat (3) @(negedge clk);
    #1 bp = pops;
    start_load(t, b);
    n_cmp++; if (b !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b required 1", b); end
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL full_timeout: in_done never rose"); end
    n_cmp++; if (done_cyc !== t + 131) begin n_err++; $display("FAIL full_done_cyc: got %0d required %0d", done_cyc - t, 131); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_end: got %b required 0", busy); end
    n_cmp++; if (obs.size() - rd_obs !== 128) begin n_err++; $display("FAIL full_count: got %0d required 128", obs.size() - rd_obs); end
    if (obs.size() - rd_obs >= 128) begin
      n_cmp++; if (obs[rd_obs].cyc !== t + 3) begin n_err++; $display("FAIL full_first: got t+%0d required t+3", obs[rd_obs].cyc - t); end
      n_cmp++; if (obs[rd_obs + 127].cyc !== t + 130) begin n_err++; $display("FAIL full_last: got t+%0d required t+130", obs[rd_obs + 127].cyc - t); end
    end
    n_cmp++; if (pops - bp !== 128) begin n_err++; $display("FAIL full_pops: got %0d required 128", pops - bp); end
    st = 1'b0;
    for (int i = 0; i < 128 && rd_obs < obs.size(); i++) begin
      o = obs[rd_obs]; rd_obs++; e = exq.pop_front(); st |= e.bad;
      n_cmp++;
      if ({o.er, o.aa, o.da, o.ab, o.db} !== {st, e.aa, e.da, e.ab, e.db}) begin
        n_err++; $display("FAIL full_beat%0d: got %h required %h", i, {o.er, o.aa, o.da, o.ab, o.db}, {st, e.aa, e.da, e.ab, e.db});
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b required 0", err); end
  endtask

  task automatic test_empty_stall;
    int t, bp, bl, r0; logic b, ok, stalled, st; obs_t o; exp_t e;
    fill(0, 127);
    repeat (3) @(negedge clk);
    #1 bp = pops; bl = lone; r0 = rd_obs;
    start_load(t, b);
    stalled = 1'b0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!stalled && (pops - bp >= 11)) begin
        stalled = 1'b1;
        stall_b = 1'b1;
        repeat (5) @(negedge clk);
        stall_b = 1'b0;
      end
      if (in_done) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout: in_done never rose"); end
    n_cmp++; if (lone - bl !== 0) begin n_err++; $display("FAIL stall_lone_pop: got %0d required 0", lone - bl); end
    n_cmp++; if (pops - bp !== 128) begin n_err++; $display("FAIL stall_pops: got %0d required 128", pops - bp); end
    n_cmp++; if (obs.size() - r0 !== 128) begin n_err++; $display("FAIL stall_count: got %0d required 128", obs.size() - r0); end
    if (obs.size() - r0 >= 128) begin
      n_cmp++;
      if (obs[r0 + 127].cyc - obs[r0].cyc !== 132) begin
        n_err++; $display("FAIL stall_span: got %0d required 132", obs[r0 + 127].cyc - obs[r0].cyc);
      end
    end
    st = 1'b0;
    for (int i = 0; i < 128 && rd_obs < obs.size(); i++) begin
      o = obs[rd_obs]; rd_obs++; e = exq.pop_front(); st |= e.bad;
      n_cmp++;
      if ({o.er, o.aa, o.da, o.ab, o.db} !== {st, e.aa, e.da, e.ab, e.db}) begin
        n_err++; $display("FAIL stall_beat%0d: got %h required %h", i, {o.er, o.aa, o.da, o.ab, o.db}, {st, e.aa, e.da, e.ab, e.db});
      end
    end
  endtask

  task automatic test_seq_error;
    int t; logic b, ok, st; obs_t o; exp_t e;
    for (int k = 0; k < 128; k++) push_beat(k, (k == 3) ? 8'h07 : 8'(2 * k), 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    start_load(t, b);
    n_cmp++; if (in_done !== 1'b0) begin n_err++; $display("FAIL seq_done_drop: got %b required 0", in_done); end
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL seq_timeout: in_done never rose"); end
    st = 1'b0;
    for (int i = 0; i < 128 && rd_obs < obs.size(); i++) begin
      o = obs[rd_obs]; rd_obs++; e = exq.pop_front(); st |= e.bad;
      n_cmp++;
      if ({o.er, o.aa, o.da, o.ab, o.db} !== {st, e.aa, e.da, e.ab, e.db}) begin
        n_err++; $display("FAIL seq_beat%0d: got %h required %h", i, {o.er, o.aa, o.da, o.ab, o.db}, {st, e.aa, e.da, e.ab, e.db});
      end
    end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL seq_err_sticky: got %b required 1", err); end
  endtask

  task automatic test_tag_error;
    int t, r0; logic b, ok, st; obs_t o; exp_t e;
    push_beat(0, 8'h00, 8'h00, 8'hA5);
    fill(1, 127);
    repeat (3) @(negedge clk);
    #1 r0 = rd_obs;
    start_load(t, b);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL tag_err_clear: got %b required 0", err); end
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL tag_timeout: in_done never rose"); end
    if (obs.size() > r0) begin
      n_cmp++;
      if ({obs[r0].ab, obs[r0].er} !== {8'h01, 1'b1}) begin
        n_err++; $display("FAIL tag_beat0: got addr_b %h err %b required 01 1", obs[r0].ab, obs[r0].er);
      end
    end
    st = 1'b0;
    for (int i = 0; i < 128 && rd_obs < obs.size(); i++) begin
      o = obs[rd_obs]; rd_obs++; e = exq.pop_front(); st |= e.bad;
      n_cmp++;
      if ({o.er, o.aa, o.da, o.ab, o.db} !== {st, e.aa, e.da, e.ab, e.db}) begin
        n_err++; $display("FAIL tag_beat%0d: got %h required %h", i, {o.er, o.aa, o.da, o.ab, o.db}, {st, e.aa, e.da, e.ab, e.db});
      end
    end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL tag_err: got %b required 1", err); end
  endtask

  task automatic test_overflow;
    int t, bp, r0; logic b, ok, st; obs_t o; exp_t e;
    fill(0, 129);
    repeat (3) @(negedge clk);
    #1 bp = pops; r0 = rd_obs;
    start_load(t, b);
    repeat (8) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_timeout: in_done never rose"); end
    n_cmp++; if (pops - bp !== 128) begin n_err++; $display("FAIL ovf_pops: got %0d required 128", pops - bp); end
    n_cmp++; if ((wr_a - rd_a !== 2) || (wr_b - rd_b !== 2)) begin
      n_err++; $display("FAIL ovf_left: got %0d/%0d required 2/2", wr_a - rd_a, wr_b - rd_b);
    end
    n_cmp++; if (done_cyc !== t + 131) begin n_err++; $display("FAIL ovf_done_cyc: got t+%0d required t+131", done_cyc - t); end
    n_cmp++; if (obs.size() - r0 !== 128) begin n_err++; $display("FAIL ovf_count: got %0d required 128", obs.size() - r0); end
    st = 1'b0;
    for (int i = 0; i < 128 && rd_obs < obs.size(); i++) begin
      o = obs[rd_obs]; rd_obs++; e = exq.pop_front(); st |= e.bad;
      n_cmp++;
      if ({o.er, o.aa, o.da, o.ab, o.db} !== {st, e.aa, e.da, e.ab, e.db}) begin
        n_err++; $display("FAIL ovf_beat%0d: got %h required %h", i, {o.er, o.aa, o.da, o.ab, o.db}, {st, e.aa, e.da, e.ab, e.db});
      end
    end
    // The two leftover beats carry addresses 0/1 and 2/3, so the next load starts with them.
    fill(2, 127);
    #1 r0 = rd_obs;
    start_load(t, b);
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf2_timeout: in_done never rose"); end
    n_cmp++; if (obs.size() - r0 !== 128) begin n_err++; $display("FAIL ovf2_count: got %0d required 128", obs.size() - r0); end
    st = 1'b0;
    for (int i = 0; i < 128 && rd_obs < obs.size(); i++) begin
      o = obs[rd_obs]; rd_obs++; e = exq.pop_front(); st |= e.bad;
      n_cmp++;
      if ({o.er, o.aa, o.da, o.ab, o.db} !== {st, e.aa, e.da, e.ab, e.db}) begin
        n_err++; $display("FAIL ovf2_beat%0d: got %h required %h", i, {o.er, o.aa, o.da, o.ab, o.db}, {st, e.aa, e.da, e.ab, e.db});
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL ovf2_err: got %b required 0", err); end
  endtask

  task automatic test_reset_midload;
    int t, r0; logic b, ok, st; obs_t o; exp_t e;
    fill(0, 127);
    repeat (3) @(negedge clk);
    #1 r0 = rd_obs;
    start_load(t, b);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (obs.size() - r0 >= 40) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_wait40: got %0d writes required 40", obs.size() - r0); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_a_rdreq, fifo_b_rdreq, ram_we, busy, in_done, err} !== 6'b0) begin
      n_err++; $display("FAIL rst_async_ctrl: got %b required 000000", {fifo_a_rdreq, fifo_b_rdreq, ram_we, busy, in_done, err});
    end
    n_cmp++;
    if ({ram_addr_a, ram_din_a, ram_addr_b, ram_din_b} !== 48'h0) begin
      n_err++; $display("FAIL rst_async_data: got %h required 0", {ram_addr_a, ram_din_a, ram_addr_b, ram_din_b});
    end
    @(negedge clk); #1;
    exq.delete();
    wr_a = rd_a;
    wr_b = rd_b;
    rd_obs = obs.size();
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({busy, in_done, fifo_a_rdreq} !== 3'b000) begin
      n_err++; $display("FAIL rst_idle: got %b required 000", {busy, in_done, fifo_a_rdreq});
    end
    fill(0, 127);
    repeat (3) @(negedge clk);
    #1 r0 = rd_obs;
    start_load(t, b);
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_reload_timeout: in_done never rose"); end
    n_cmp++; if (obs.size() - r0 !== 128) begin n_err++; $display("FAIL rst_reload_count: got %0d required 128", obs.size() - r0); end
    st = 1'b0;
    for (int i = 0; i < 128 && rd_obs < obs.size(); i++) begin
      o = obs[rd_obs]; rd_obs++; e = exq.pop_front(); st |= e.bad;
      n_cmp++;
      if ({o.er, o.aa, o.da, o.ab, o.db} !== {st, e.aa, e.da, e.ab, e.db}) begin
        n_err++; $display("FAIL rst_beat%0d: got %h required %h", i, {o.er, o.aa, o.da, o.ab, o.db}, {st, e.aa, e.da, e.ab, e.db});
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    test_full_load;
    test_empty_stall;
    test_seq_error;
    test_tag_error;
    test_overflow;
    test_reset_midload;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
